ex_alu_iter: RTL
================

// Module: ex_alu_iter
// PURPOSE
//  EX-stage ALU datapath. It consumes the 4-bit ALU operation code produced by the EX
//  ALU-control decode, together with the two forwarded operands.
//  Every result is registered; this register forms the EX/MEM result register.
//  ADD/SUB/SLT/SLTU/XOR/OR/AND/LUI complete in 1 cycle. SLL/SRL/SRA run on an iterative
//  shifter, SHIFT_STEP bits per cycle, and stall the pipeline through in_ready/stall.
// PARAMETERS
//  XLEN        32  operand/result width
//  SHIFT_STEP  8   max shift distance per cycle (power of 2, 1..32)
// PORTS
//  clk        in   1     single clock, rising edge
//  rst_n      in   1     asynchronous active-low reset
//  in_valid   in   1     operation presented this cycle
//  in_ready   out  1     unit can accept (state==IDLE)
//  alu_op     in   4     `ALUADD/`ALUSUB/`ALUSLL/`ALUSLT/`ALUSLTU/`ALUXOR/`ALUSRL/`ALUSRA/
//                        `ALUOR/`ALUAND/`ALULUI (parameters.svh); 4'b1111 = invalid
//  src1       in   XLEN  rs1 operand (forwarded)
//  src2       in   XLEN  rs2 or immediate operand
//  flush      in   1     kill the in-flight/presented op (branch mispredict)
//  stall      out  1     to hazard unit; equals ~in_ready
//  out_valid  out  1     one-cycle pulse: result valid
//  result     out  XLEN  registered result
//  zero       out  1     registered (result==0)
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, out_valid=0, result=0, zero=1, in_ready=1.
//  Accept: in_valid & in_ready & ~flush at a rising edge.
//  Non-shift op accepted at edge k: result/zero/out_valid=1 visible after edge k (latency 1).
//   ADD/SUB: mod 2^XLEN wrap. SLT: signed compare. SLTU: unsigned compare.
//   LUI: result=src2. 4'b1111 or undefined code: result=0, out_valid still pulses.
//  Shift op: shamt=src2[4:0]; N = max(1, ceil(shamt/SHIFT_STEP)) cycles.
//   On accept: latch src1/op; shift by min(shamt,SHIFT_STEP); rem=shamt-step.
//   rem==0: out_valid next cycle. Otherwise enter SHIFT.
//   SHIFT: each cycle shift by min(rem,SHIFT_STEP); at rem==0 pulse out_valid, go IDLE.
//   out_valid is visible N cycles after the accept edge.
//   SRA replicates the latched sign bit on every step; SRL/SLL fill zeros.
//  FSM: IDLE -(accept shift, shamt>SHIFT_STEP)-> SHIFT -(last step)-> IDLE.
//   In-flight operand and op are held internally, so input changes during SHIFT are ignored.
//  in_ready is low throughout SHIFT. A new op may be accepted the cycle out_valid is high.
//  out_valid is low whenever no completion occurs; result/zero hold their last value.
//  Flush:
//   in IDLE: the presented op is dropped (flush wins over in_valid); no out_valid.
//   in SHIFT: abort to IDLE next edge, no out_valid, in_ready=1 the following cycle.
//   flush in the cycle a completion is registered suppresses that out_valid.
//  Reset mid-shift returns to IDLE immediately; no out_valid is produced.
//  Downstream always accepts; there is no out_ready.
// TESTING
//  1 ADD 0xFFFFFFFF+1 -> 1 cycle later: out_valid=1, result=0, zero=1.
//  2 SLT src1=0xFFFFFFFF, src2=1 -> result 1. SLTU with the same operands -> result 0.
//  3 SRA src1=0x80000000, shamt=20 (STEP=8) -> stall high 2 cycles; out_valid 3 cycles
//    after accept; result=0xFFFFF800.
//  4 SLL shamt=0 -> 1-cycle latency, result=src1. SRL shamt=31 -> 4 cycles, 0x80000000 -> 1.
//  5 Start SLL shamt=31, assert flush on the 2nd SHIFT cycle -> no out_valid; in_ready back to 1.
//    Next ADD 2+3 -> result 5.
//  6 Deassert rst_n mid-shift -> out_valid=0, result=0, in_ready=1 immediately.
//    alu_op=4'b1111 -> result 0, out_valid pulses.

Source files
------------

// File: rtl/ex_alu_iter.sv
// EX-stage ALU with a registered EX/MEM result. Shifts run on an iterative shifter
// that moves at most SHIFT_STEP bits per cycle and holds off new ops via in_ready/stall.
module ex_alu_iter #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  localparam logic [5:0] STEP = 6'(SHIFT_STEP);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_acc;
  logic [5:0]      r_rem;
  logic [3:0]      r_op;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_out_valid;

  logic            w_accept;
  logic            w_is_shift;
  logic [5:0]      w_cur_rem;
  logic [5:0]      w_step;
  logic [5:0]      w_rem_nxt;
  logic [XLEN-1:0] w_sh_in;
  logic [3:0]      w_sh_op;
  logic [XLEN-1:0] w_sh_out;
  logic [XLEN-1:0] w_alu;

  assign in_ready   = (r_state == IDLE);
  assign stall      = ~in_ready;
  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign zero       = r_zero;

  assign w_accept   = in_valid & in_ready & ~flush;
  assign w_is_shift = (alu_op == ALU_SLL) || (alu_op == ALU_SRL) || (alu_op == ALU_SRA);

  // The shifter is shared: in IDLE it takes the live operands, in SHIFT the latched ones.
  assign w_cur_rem  = (r_state == IDLE) ? {1'b0, src2[4:0]} : r_rem;
  assign w_step     = (w_cur_rem > STEP) ? STEP : w_cur_rem;
  assign w_rem_nxt  = w_cur_rem - w_step;
  assign w_sh_in    = (r_state == IDLE) ? src1 : r_acc;
  assign w_sh_op    = (r_state == IDLE) ? alu_op : r_op;

  always_comb begin
    w_sh_out = w_sh_in;
    case (w_sh_op)
      ALU_SLL: w_sh_out = w_sh_in << w_step;
      ALU_SRL: w_sh_out = w_sh_in >> w_step;
      ALU_SRA: w_sh_out = XLEN'($signed(w_sh_in) >>> w_step);
      default: w_sh_out = w_sh_in;
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (alu_op)
      ALU_ADD:  w_alu = src1 + src2;
      ALU_SUB:  w_alu = src1 - src2;
      ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (src1 < src2)};
      ALU_XOR:  w_alu = src1 ^ src2;
      ALU_OR:   w_alu = src1 | src2;
      ALU_AND:  w_alu = src1 & src2;
      ALU_LUI:  w_alu = src2;
      ALU_SLL, ALU_SRL, ALU_SRA: w_alu = w_sh_out;
      default:  w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_is_shift && (w_rem_nxt != 6'd0)) w_state_nxt = SHIFT;
      SHIFT:   if (flush || (w_rem_nxt == 6'd0)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_rem       <= '0;
      r_op        <= '0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (r_state == IDLE) begin
        if (w_accept) begin
          if (w_is_shift && (w_rem_nxt != 6'd0)) begin
            r_acc <= w_sh_out;
            r_rem <= w_rem_nxt;
            r_op  <= alu_op;
          end else begin
            r_result    <= w_alu;
            r_zero      <= (w_alu == '0);
            r_out_valid <= 1'b1;
          end
        end
      end else if (!flush) begin
        r_acc <= w_sh_out;
        r_rem <= w_rem_nxt;
        if (w_rem_nxt == 6'd0) begin
          r_result    <= w_sh_out;
          r_zero      <= (w_sh_out == '0);
          r_out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
